// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video scanout has fixed priority, with a streak limit that
// guarantees the CPU a slot after MAX_VID_STREAK consecutive video grants.
module vram_arbiter #(
   parameter int ADDR_W         = 13,
   parameter int DATA_W         = 8,
   parameter int RD_LAT         = 1,
   parameter int MAX_VID_STREAK = 4
) (
   input  logic              CLK_25MHZ,
   input  logic              RESET,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int STREAK_W = 4;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);

   logic [STREAK_W-1:0] streak;
   logic                force_cpu;
   logic                grant_vid;
   logic                grant_cpu;
   logic                issue_rd;
   logic [RD_LAT:0]     tag_vld_p;
   logic [RD_LAT:0]     tag_own_p;

   function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
      return (v >= STREAK_MAX) ? STREAK_MAX : v + STREAK_W'(1);
   endfunction

   // Grant decision; internal grants ignore reset because every flop they feed is held in reset.
   always_comb begin
      force_cpu = cpu_req && (streak == STREAK_MAX);
      grant_vid = vid_req && !force_cpu;
      grant_cpu = cpu_req && !grant_vid;
      issue_rd  = grant_vid || (grant_cpu && !cpu_we);
      vid_ack   = grant_vid && !RESET;
      cpu_ack   = grant_cpu && !RESET;
   end

   always_ff @(posedge CLK_25MHZ or posedge RESET) begin
      if (RESET) begin
         streak <= '0;
      end else if (grant_vid && cpu_req) begin
         streak <= sat_inc(streak);
      end else begin
         streak <= '0;
      end
   end

   // Stage p0: granted request lands on the RAM port.
   always_ff @(posedge CLK_25MHZ or posedge RESET) begin
      if (RESET) begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         ram_en <= grant_vid || grant_cpu;
         ram_we <= grant_cpu && cpu_we;
         if (grant_vid) begin
            ram_addr <= vid_addr;
         end else if (grant_cpu) begin
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
         end
      end
   end

   // Tag pipe: entry 0 travels with the issue, entry RD_LAT lines up with ram_rdata.
   always_ff @(posedge CLK_25MHZ or posedge RESET) begin
      if (RESET) begin
         tag_vld_p <= '0;
         tag_own_p <= '0;
      end else begin
         tag_vld_p <= {tag_vld_p[RD_LAT-1:0], issue_rd};
         tag_own_p <= {tag_own_p[RD_LAT-1:0], grant_cpu};
      end
   end

   // Return stage: capture read data into the owner's register and pulse its rvalid.
   always_ff @(posedge CLK_25MHZ or posedge RESET) begin
      if (RESET) begin
         vid_rvalid <= 1'b0;
         cpu_rvalid <= 1'b0;
         vid_rdata  <= '0;
         cpu_rdata  <= '0;
      end else begin
         vid_rvalid <= tag_vld_p[RD_LAT] && !tag_own_p[RD_LAT];
         cpu_rvalid <= tag_vld_p[RD_LAT] && tag_own_p[RD_LAT];
         if (tag_vld_p[RD_LAT] && !tag_own_p[RD_LAT]) begin
            vid_rdata <= ram_rdata;
         end
         if (tag_vld_p[RD_LAT] && tag_own_p[RD_LAT]) begin
            cpu_rdata <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model with 1-cycle read latency, directed scenarios plus a
// random phase, all read returns checked against a scoreboard filled at ack time.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vid_req = 1'b0;
   logic [12:0] vid_addr = '0;
   logic        vid_ack;
   logic        vid_rvalid;
   logic [7:0]  vid_rdata;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [12:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ack;
   logic        cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic        ram_en;
   logic        ram_we;
   logic [12:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = '0;

   vram_arbiter #(
      .ADDR_W(13), .DATA_W(8), .RD_LAT(1), .MAX_VID_STREAK(4)
   ) dut (
      .CLK_25MHZ(clk), .RESET(rst),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #20 clk = ~clk;

   logic [7:0] mem  [0:8191];
   logic [7:0] gold [0:8191];

   // Block RAM model: data appears one cycle after the enable is sampled.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   typedef struct {
      bit         own;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t        sb [$];
   byte         glog [$];
   int          n_chk = 0;
   int          n_bad = 0;
   int          cyc = 0;
   bit          prev_iss = 1'b0;
   bit          prev_we = 1'b0;
   logic [12:0] prev_addr = '0;
   logic [7:0]  prev_wdata = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: issue checks, scoreboard push on ack, pop on rvalid.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         check("rst_vack", 32'(vid_ack), 0);
         check("rst_cack", 32'(cpu_ack), 0);
         check("rst_en", 32'(ram_en), 0);
         check("rst_vrv", 32'(vid_rvalid), 0);
         check("rst_crv", 32'(cpu_rvalid), 0);
         sb.delete();
         prev_iss = 1'b0;
      end else begin
         if (prev_iss) begin
            check("iss_en", 32'(ram_en), 1);
            check("iss_addr", 32'(ram_addr), 32'(prev_addr));
            check("iss_we", 32'(ram_we), 32'(prev_we));
            if (prev_we) check("iss_wdata", 32'(ram_wdata), 32'(prev_wdata));
         end else begin
            check("idle_en", 32'(ram_en), 0);
         end
         check("one_ack", 32'(vid_ack && cpu_ack), 0);
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("rv_missing", 32'(cyc), 32'(sb[0].cyc));
            void'(sb.pop_front());
         end
         if (vid_rvalid || cpu_rvalid) begin
            check("rv_both", 32'(vid_rvalid && cpu_rvalid), 0);
            if (sb.size() == 0) begin
               check("rv_spurious", 1, 0);
            end else begin
               e = sb.pop_front();
               check("rv_cyc", 32'(cyc), 32'(e.cyc));
               check("rv_own", 32'(cpu_rvalid), 32'(e.own));
               check("rv_data", 32'(e.own ? cpu_rdata : vid_rdata), 32'(e.data));
            end
         end
         prev_iss = 1'b0;
         if (vid_ack) begin
            prev_iss  = 1'b1;
            prev_we   = 1'b0;
            prev_addr = vid_addr;
            sb.push_back('{1'b0, gold[vid_addr], cyc + 3});
            glog.push_back("V");
         end else if (cpu_ack) begin
            prev_iss   = 1'b1;
            prev_we    = cpu_we;
            prev_addr  = cpu_addr;
            prev_wdata = cpu_wdata;
            if (cpu_we) gold[cpu_addr] = cpu_wdata;
            else        sb.push_back('{1'b1, gold[cpu_addr], cyc + 3});
            glog.push_back("C");
         end else begin
            glog.push_back("-");
         end
      end
   end

   task automatic cpu_op(input logic we, input logic [12:0] a, input logic [7:0] d);
      bit got = 1'b0;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (cpu_ack) got = 1'b1;
      end
      if (!got) check("ack_timeout", 0, 1);
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   task automatic check_log(input string tag, input string pat);
      check({tag, "_len"}, 32'(glog.size()), 32'(pat.len()));
      for (int i = 0; i < pat.len() && i < glog.size(); i++)
         check(tag, 32'(glog[i]), 32'(pat[i]));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8192; i++) begin
         mem[i]  = 8'(i) ^ 8'h3C;
         gold[i] = 8'(i) ^ 8'h3C;
      end
      mem[13'h0123] = 8'hA5; gold[13'h0123] = 8'hA5;
      mem[13'h0010] = 8'h11; gold[13'h0010] = 8'h11;
      mem[13'h0020] = 8'h22; gold[13'h0020] = 8'h22;
      mem[13'h0030] = 8'h33; gold[13'h0030] = 8'h33;

      // Reset held with both requesters active
      vid_req = 1'b1; vid_addr = 13'h0200; cpu_req = 1'b1; cpu_addr = 13'h0201;
      repeat (3) begin
         @(negedge clk);
         check("rst_vrdata", 32'(vid_rdata), 0);
         check("rst_crdata", 32'(cpu_rdata), 0);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("rel_vack", 32'(vid_ack), 1);
      check("rel_cack", 32'(cpu_ack), 0);
      @(posedge clk); #1; vid_req = 1'b0; cpu_req = 1'b0;
      repeat (5) @(posedge clk);

      // Lone CPU read
      cpu_op(1'b0, 13'h0123, 8'h00);
      @(negedge clk);
      check("rd_en", 32'(ram_en), 1);
      check("rd_addr", 32'(ram_addr), 32'h0123);
      @(negedge clk);
      check("rd_rv_early", 32'(cpu_rvalid), 0);
      @(negedge clk);
      check("rd_rv", 32'(cpu_rvalid), 1);
      check("rd_data", 32'(cpu_rdata), 32'hA5);
      repeat (3) @(posedge clk);

      // Starvation guard
      #1;
      glog.delete();
      vid_req = 1'b1; vid_addr = 13'h0040; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0041;
      repeat (10) @(posedge clk);
      #1; vid_req = 1'b0; cpu_req = 1'b0;
      check_log("starve", "VVVVCVVVVC");
      repeat (4) @(posedge clk);

      // Streak cleared by a one-cycle cpu_req drop
      #1;
      glog.delete();
      vid_req = 1'b1; cpu_req = 1'b1;
      repeat (3) @(posedge clk);
      #1; cpu_req = 1'b0;
      @(posedge clk); #1; cpu_req = 1'b1;
      repeat (5) @(posedge clk);
      #1; vid_req = 1'b0; cpu_req = 1'b0;
      check_log("streak_clr", "VVVVVVVVC");
      repeat (4) @(posedge clk);

      // Mixed owners back to back
      #1;
      vid_req = 1'b1; vid_addr = 13'h0010; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0020;
      @(negedge clk); check("mix_v0", 32'(vid_ack), 1);
      @(posedge clk); #1; vid_req = 1'b0;
      @(negedge clk); check("mix_c1", 32'(cpu_ack), 1);
      @(posedge clk); #1; vid_req = 1'b1; vid_addr = 13'h0030; cpu_req = 1'b0;
      @(negedge clk); check("mix_v2", 32'(vid_ack), 1);
      @(posedge clk); #1; vid_req = 1'b0;
      @(negedge clk);
      check("mix_rv0", 32'(vid_rvalid), 1); check("mix_d0", 32'(vid_rdata), 32'h11);
      @(negedge clk);
      check("mix_rv1", 32'(cpu_rvalid), 1); check("mix_d1", 32'(cpu_rdata), 32'h22);
      @(negedge clk);
      check("mix_rv2", 32'(vid_rvalid), 1); check("mix_d2", 32'(vid_rdata), 32'h33);
      repeat (3) @(posedge clk);

      // CPU write then read back
      cpu_op(1'b1, 13'h1BFF, 8'h5A);
      @(negedge clk);
      check("wr_we", 32'(ram_we), 1);
      check("wr_addr", 32'(ram_addr), 32'h1BFF);
      check("wr_data", 32'(ram_wdata), 32'h5A);
      repeat (3) begin
         @(negedge clk);
         check("wr_norv", 32'(cpu_rvalid), 0);
         check("wr_rdata_hold", 32'(cpu_rdata), 32'h22);
      end
      cpu_op(1'b0, 13'h1BFF, 8'h00);
      repeat (2) @(negedge clk);
      @(negedge clk);
      check("wrrd_rv", 32'(cpu_rvalid), 1);
      check("wrrd_data", 32'(cpu_rdata), 32'h5A);
      repeat (3) @(posedge clk);

      // Same again with a reset pulse between ack and rvalid
      cpu_op(1'b1, 13'h1BFF, 8'h77);
      repeat (3) @(posedge clk);
      cpu_op(1'b0, 13'h1BFF, 8'h00);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("rstfl_norv", 32'(cpu_rvalid), 0);
         check("rstfl_en", 32'(ram_en), 0);
         check("rstfl_rdata", 32'(cpu_rdata), 0);
      end

      // Random traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         vid_req   = ($urandom_range(0, 3) != 0);
         vid_addr  = 13'($urandom_range(0, 8191));
         cpu_req   = ($urandom_range(0, 2) != 0);
         cpu_we    = ($urandom_range(0, 2) == 0);
         cpu_addr  = 13'($urandom_range(0, 63));
         cpu_wdata = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1; vid_req = 1'b0; cpu_req = 1'b0;
      repeat (8) @(posedge clk);
      check("drain", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
